// File: rtl/stall_scheduler.sv
// Round-robin stall scheduler: requesters post stall lengths, one stall is
// counted at a time, and the program counter is held while any work remains.
module stall_scheduler #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  output logic                  pc_en,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       drop,
  output logic [CNT_W-1:0]      cur_cnt,
  output logic                  dbg_count
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] lenq_q [NREQ];
  logic [IDX_W-1:0] last_g_q, last_g_d;
  logic [NREQ-1:0]  grant_d;
  logic [CNT_W-1:0] cnt_d;
  logic [NREQ-1:0]  accept, reject;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             last_cycle;
  logic             load;

  // req is a single-cycle pulse with no back-pressure: it is accepted when the
  // requester has nothing pending or in service, otherwise it is discarded and
  // reported on drop one cycle later.
  assign accept     = req & ~pending_q & ~grant;
  assign reject     = req & (pending_q | grant);
  assign last_cycle = (state_q == COUNT) && (cur_cnt == CNT_W'(1));

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_c;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    idx_c   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_g_q) + k) % NREQ;
      idx_c = IDX_W'(idx);
      if (!win_vld && pending_q[idx_c]) begin
        win_vld = 1'b1;
        win_idx = idx_c;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    cnt_d     = cur_cnt;
    last_g_d  = last_g_q;
    pending_d = pending_q | accept;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) load = 1'b1;
      end
      COUNT: begin
        if (last_cycle) begin
          if (win_vld) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cur_cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A zero length still costs one cycle, so the counter never underflows.
    if (load) begin
      state_d            = COUNT;
      grant_d            = '0;
      grant_d[win_idx]   = 1'b1;
      pending_d[win_idx] = 1'b0;
      cnt_d              = (lenq_q[win_idx] == '0) ? CNT_W'(1) : lenq_q[win_idx];
      last_g_d           = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      last_g_q  <= IDX_W'(NREQ - 1);
      grant     <= '0;
      cur_cnt   <= '0;
      drop      <= '0;
      for (int i = 0; i < NREQ; i++) lenq_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_g_q  <= last_g_d;
      grant     <= grant_d;
      cur_cnt   <= cnt_d;
      drop      <= reject;
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) lenq_q[i] <= len[i*CNT_W +: CNT_W];
      end
    end
  end

  assign done      = last_cycle ? grant : '0;
  assign pc_en     = (state_q == IDLE) && (pending_q == '0);
  assign dbg_count = (state_q == COUNT);

endmodule

// File: tb/tb_stall_scheduler.sv
// Bench for stall_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_stall_scheduler;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ*CNT_W-1:0] len   = '0;
  logic                  pc_en;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       drop;
  logic [CNT_W-1:0]      cur_cnt;
  logic                  dbg_count;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  stall_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len(len), .pc_en(pc_en),
    .grant(grant), .done(done), .drop(drop), .cur_cnt(cur_cnt),
    .dbg_count(dbg_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_act;   // requester in service, -1 when none
  int              m_rem;   // cycles left including the current one
  int              m_last;
  bit [NREQ-1:0]   m_pend;
  bit [NREQ-1:0]   m_drop;
  int              m_len [NREQ];

  task automatic model_reset();
    m_act  = -1;
    m_rem  = 0;
    m_last = NREQ - 1;
    m_pend = '0;
    m_drop = '0;
    for (int i = 0; i < NREQ; i++) m_len[i] = 0;
  endtask

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      int idx = (m_last + k) % NREQ;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [NREQ-1:0] cap;
    int win;
    cap    = '0;
    m_drop = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (m_pend[i] || m_act == i) m_drop[i] = 1'b1;
        else cap[i] = 1'b1;
      end
    end
    if (m_act < 0 || m_rem == 1) begin
      m_act = -1;
      m_rem = 0;
      win = pick();
      if (win >= 0) begin
        m_act        = win;
        m_pend[win]  = 1'b0;
        m_rem        = (m_len[win] < 1) ? 1 : m_len[win];
        m_last       = win;
      end
    end else begin
      m_rem = m_rem - 1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (cap[i]) begin
        m_pend[i] = 1'b1;
        m_len[i]  = int'(len[i*CNT_W +: CNT_W]);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [NREQ-1:0] eg;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        eg = '0;
        if (m_act >= 0) eg[m_act] = 1'b1;
        check("pc_en",     pc_en,     (m_act < 0) && (m_pend == '0));
        check("grant",     grant,     eg);
        check("done",      done,      (m_act >= 0 && m_rem == 1) ? eg : '0);
        check("drop",      drop,      m_drop);
        check("cur_cnt",   cur_cnt,   m_rem);
        check("dbg_count", dbg_count, m_act >= 0);
      end
    end
  end

  // ---------------- directed measurement ----------------
  int          mtr_low, mtr_done, mtr_done_cnt, mtr_drop;
  logic [63:0] mtr_gseq, mtr_cseq;

  task automatic measure(input int max_cyc, input int inj_at,
                         input logic [NREQ-1:0] inj_req,
                         input logic [NREQ*CNT_W-1:0] inj_len);
    logic [NREQ-1:0] prev;
    int n;
    mtr_low = 0; mtr_done = 0; mtr_done_cnt = 0; mtr_drop = 0;
    mtr_gseq = '0; mtr_cseq = '0;
    prev = '0;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      req = (n == inj_at) ? inj_req : '0;
      if (n == inj_at) len = inj_len;
      if (!pc_en) mtr_low++;
      if (grant != '0 && grant != prev) mtr_gseq = (mtr_gseq << 4) | {60'd0, grant};
      prev = grant;
      if (grant != '0) mtr_cseq = (mtr_cseq << 4) | {60'd0, cur_cnt[3:0]};
      if (done != '0) begin
        mtr_done++;
        mtr_done_cnt = int'(cur_cnt);
      end
      if (drop != '0) mtr_drop++;
      if (pc_en && mtr_low > 0 && req == '0) break;
      if (n >= max_cyc) begin
        checks++;
        errors++;
        $display("FAIL measure_timeout: got %0d cycles without idle, required fewer than %0d", n, max_cyc);
        break;
      end
    end
  endtask

  function automatic logic [NREQ*CNT_W-1:0] lens(input int l0, input int l1, input int l2, input int l3);
    return {CNT_W'(l3), CNT_W'(l2), CNT_W'(l1), CNT_W'(l0)};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int bad;

    // Reset values while reset is held across clock edges.
    repeat (2) @(negedge clk);
    check("rst_pc_en",   pc_en,   1'b1);
    check("rst_grant",   grant,   '0);
    check("rst_done",    done,    '0);
    check("rst_drop",    drop,    '0);
    check("rst_cur_cnt", cur_cnt, '0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Simultaneous requests straight after reset: 0,1,2,3 back-to-back.
    req = 4'b1111; len = lens(2, 2, 2, 2);
    measure(60, 0, '0, '0);
    check("sim_low",   mtr_low,  9);
    check("sim_order", mtr_gseq, 64'h1248);
    check("sim_cnts",  mtr_cseq, 64'h21212121);
    check("sim_done",  mtr_done, 4);

    // Single stall of five cycles.
    @(negedge clk);
    req = 4'b0001; len = lens(5, 0, 0, 0);
    measure(40, 0, '0, '0);
    check("single_low",     mtr_low,      6);
    check("single_grant",   mtr_gseq,     64'h1);
    check("single_cnts",    mtr_cseq,     64'h54321);
    check("single_done",    mtr_done,     1);
    check("single_donecnt", mtr_done_cnt, 1);

    // Zero length behaves as a one-cycle stall.
    @(negedge clk);
    req = 4'b0100; len = lens(0, 0, 0, 0);
    measure(40, 0, '0, '0);
    check("zero_low",   mtr_low,  2);
    check("zero_grant", mtr_gseq, 64'h4);
    check("zero_cnts",  mtr_cseq, 64'h1);
    check("zero_done",  mtr_done, 1);

    // Overrun: repeat request in cycle 3 of its own stall is dropped.
    @(negedge clk);
    req = 4'b0010; len = lens(0, 10, 0, 0);
    measure(60, 4, 4'b0010, lens(0, 3, 0, 0));
    check("ovr_low",   mtr_low,  11);
    check("ovr_grant", mtr_gseq, 64'h2);
    check("ovr_cnts",  mtr_cseq, 64'ha987654321);
    check("ovr_done",  mtr_done, 1);
    check("ovr_drop",  mtr_drop, 1);

    // Round robin: after requester 1, pending 3 and 0 -> 3 first.
    @(negedge clk);
    req = 4'b0010; len = lens(0, 1, 0, 0);
    measure(40, 0, '0, '0);
    @(negedge clk);
    req = 4'b1001; len = lens(1, 1, 1, 1);
    measure(40, 0, '0, '0);
    check("rr_order", mtr_gseq, 64'h81);
    check("rr_low",   mtr_low,  3);

    // Reset in the middle of a stall with two requests pending.
    @(negedge clk);
    req = 4'b0001; len = lens(6, 0, 0, 0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 4'b0110; len = lens(0, 3, 3, 0);
    @(negedge clk);
    req = '0;
    n = 0;
    while (cur_cnt != CNT_W'(4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_cnt_before",   cur_cnt, 4);
    check("mid_grant_before", grant,   4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc_en",   pc_en,   1'b1);
    check("mid_rst_grant",   grant,   '0);
    check("mid_rst_done",    done,    '0);
    check("mid_rst_drop",    drop,    '0);
    check("mid_rst_cur_cnt", cur_cnt, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (grant != '0 || !pc_en || done != '0) bad++;
    end
    check("mid_no_service", bad, 0);

    // Randomized traffic with one asynchronous reset pulse in the middle.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        req[i] = ($urandom_range(0, 5) == 0);
        len[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
      end
      if (c == 200) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    req = '0;
    n = 0;
    while (!pc_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("final_idle", pc_en, 1'b1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stall_scheduler.md
STALL_SCHEDULER -- requirements
Module: stall_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of stall requesters.
REQ-002 Parameter CNT_W, default 8: width of each stall length and of the down-counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester stall request; sampled high for one cycle = one request.
REQ-006 len  input  NREQ*CNT_W  per-requester stall length in cycles; slice i = len[i*CNT_W +: CNT_W], sampled with req[i].
REQ-007 pc_en  output  1  program-counter enable; 1 = PC may advance, 0 = stalled.
REQ-008 grant  output  NREQ  one-hot; bit i high while requester i's stall is being counted.
REQ-009 done  output  NREQ  one-cycle pulse on bit i in the last counted cycle of requester i's stall.
REQ-010 drop  output  NREQ  one-cycle pulse on bit i when a req[i] is discarded.
REQ-011 cur_cnt  output  CNT_W  remaining cycles of the active stall, 0 in IDLE.

Function
REQ-012 The block SHALL hold a pending bit and a captured length register lenq[i] per requester.
REQ-013 On an edge with req[i]=1, pending[i]=0 and grant[i]=0: pending[i] SHALL set and lenq[i] SHALL capture len slice i.
REQ-014 On an edge with req[i]=1 and (pending[i]=1 or grant[i]=1): the request SHALL be discarded, lenq[i] unchanged, drop[i] pulsed the following cycle.
REQ-015 FSM states SHALL be IDLE and COUNT only.
REQ-016 IDLE: grant=0, cur_cnt=0; if any pending bit set, next edge SHALL enter COUNT with the selected requester g.
REQ-017 Selection SHALL be round-robin: first set pending bit searching upward from (last_g+1) mod NREQ, wrapping; last_g resets to NREQ-1, so requester 0 wins first.
REQ-018 Entering COUNT with g: grant SHALL = one-hot g, pending[g] cleared, cur_cnt loaded with L = max(lenq[g],1), last_g <= g.
REQ-019 COUNT: cur_cnt SHALL decrement by 1 each edge; grant held for exactly L cycles.
REQ-020 len = 0 SHALL be treated as 1 (one-cycle stall); no underflow of cur_cnt ever.
REQ-021 done[g] SHALL be high in the cycle where cur_cnt = 1 (last grant cycle); at that edge, if any pending bit set, FSM SHALL stay in COUNT and load the next winner (zero-bubble), else return to IDLE.
REQ-022 A req[g] from the active requester in its done cycle SHALL be dropped (REQ-014), not queued.
REQ-023 pc_en SHALL be combinational from registers: pc_en = (state==IDLE) and (pending==0).
REQ-024 Latency: req[i] sampled at edge k -> pc_en low from edge k; grant[i] high from edge k+1 at earliest; pc_en high again the cycle after the last done when nothing pending.
REQ-025 Simultaneous req on several bits SHALL all be captured in the same edge; service order per REQ-017.
REQ-026 Max latency from pending set to grant SHALL be bounded by the sum of the other NREQ-1 stalls (no starvation).

Reset
REQ-027 rst_n=0 SHALL immediately, without clk: state=IDLE, pending=0, lenq=0, grant=0, done=0, drop=0, cur_cnt=0, last_g=NREQ-1, pc_en=1.
REQ-028 Reset asserted mid-COUNT SHALL abort the stall without a done pulse; all pending requests lost.
REQ-029 First req sampled SHALL be the one on the first rising edge with rst_n=1 held through it.

Verification
REQ-030 Single: req[0]=1, len0=5 for one cycle -> pc_en low same cycle, grant=0001 for 5 cycles, cur_cnt 5,4,3,2,1, done[0] with cur_cnt=1, pc_en=1 next cycle.
REQ-031 Zero length: req[2]=1, len2=0 -> grant=0100 for 1 cycle, done[2] that cycle, total pc_en low 2 cycles.
REQ-032 Simultaneous: req=1111 all len=2 after reset -> grants 0001,0010,0100,1000 each 2 cycles back-to-back, no IDLE gap, pc_en low 9 cycles.
REQ-033 Overrun: req[1] len=10 then req[1] again at cycle 3 of its stall -> drop[1] one pulse, stall still ends after 10 cycles, no second service.
REQ-034 Round-robin: last_g=1, pending=1001 -> requester 3 served before 0.
REQ-035 Reset mid-stall: rst_n low at cur_cnt=4 with pending=0110 -> all outputs to reset values asynchronously, pc_en=1, no done pulse, no service after release.
